// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags cleared by clr_err.
module param_sync_fifo #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wen,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              ren,
  input  logic              clr_err,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2 ** AWIDTH;
  localparam int CW    = AWIDTH + 1;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_wptr, r_rptr, r_count;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_rvalid, r_ovf, r_udf;

  logic w_full, w_empty, w_rd_acc, w_wr_acc, w_wr_rej, w_rd_rej;

  // Full/empty come from the pointers alone so status never depends on wen/ren.
  assign w_full  = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                   (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  // A read frees a slot in the same cycle, so a write on full is accepted
  // alongside it; a read on empty never falls through to the incoming word.
  assign w_rd_acc = rstn && ren && !w_empty;
  assign w_wr_acc = rstn && wen && (!w_full || w_rd_acc);
  assign w_wr_rej = wen && !w_wr_acc;
  assign w_rd_rej = ren && w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[AWIDTH-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + CW'(1);
      if (w_rd_acc) begin
        r_rptr  <= r_rptr + CW'(1);
        r_rdata <= r_mem[r_rptr[AWIDTH-1:0]];
      end
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
      // A new error in the clearing cycle keeps the flag set.
      r_ovf <= (r_ovf && !clr_err) || w_wr_rej;
      r_udf <= (r_udf && !clr_err) || w_rd_rej;
    end
  end

  assign rdata        = r_rdata;
  assign rvalid       = r_rvalid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomized + directed bench for param_sync_fifo: a queue reference model feeds a
// scoreboard of expected read data, drained by an independent rvalid monitor.
module tb_param_sync_fifo;
  localparam int DW = 8, AW = 3, DEPTH = 8, AF = 6, AE = 2;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          wen = 1'b0, ren = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  param_sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rstn(rstn), .wen(wen), .wdata(wdata), .ren(ren), .clr_err(clr_err),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [DW-1:0] mq[$];   // reference FIFO contents
  logic [DW-1:0] sb[$];   // expected read data, oldest first
  bit m_ovf = 0, m_udf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL rdata_unexpected: got %0h with no read outstanding", rdata);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        chk("rdata", rdata, e);
      end
    end
  end

  task automatic check_status(input bit exp_rv);
    int c;
    c = mq.size();
    chk("count", count, c);
    chk("full", full, c == DEPTH);
    chk("empty", empty, c == 0);
    chk("almost_full", almost_full, c >= AF);
    chk("almost_empty", almost_empty, c <= AE);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    chk("rvalid", rvalid, exp_rv);
  endtask

  // Called just after a posedge; drives one cycle and checks the result.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit rd, wr;
    wen = w; wdata = d; ren = r; clr_err = c;
    rd = r && (mq.size() > 0);
    wr = w && (mq.size() < DEPTH || rd);
    if (rd) sb.push_back(mq.pop_front());
    if (wr) mq.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wr);
    m_udf = (m_udf && !c) || (r && !rd);
    @(posedge clk); #1;
    wen = 0; ren = 0; clr_err = 0;
    check_status(rd);
  endtask

  initial begin
    logic [DW-1:0] d;
    int written;
    #12;
    check_status(0);
    chk("rdata_reset", rdata, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Fill 0x11..0x88, then one rejected write
    for (int i = 1; i <= 8; i++) begin
      d = DW'(i * 8'h11);
      step(1, d, 0, 0);
    end
    step(1, 8'h99, 0, 0);
    // Clear, then clear coincident with a rejected write
    step(0, 0, 0, 1);
    step(1, 8'h9A, 0, 1);
    step(0, 0, 0, 1);
    // Full with simultaneous read+write
    step(1, 8'hAA, 1, 0);
    // Drain plus one extra read on empty
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    // Empty with simultaneous read+write: write only
    step(1, 8'h3C, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Staggered stream across two pointer wraps, occupancy kept in 1..5
    written = 0;
    while (written < 20 || mq.size() > 0) begin
      bit w, r;
      w = (written < 20) && (mq.size() < 5);
      r = (mq.size() > 1) || (written == 20 && mq.size() > 0);
      if (written < 20 && (written % 3) == 2 && mq.size() < 4) r = 0;
      d = DW'($urandom);
      if (w) written++;
      step(w, d, r, 0);
    end

    // Load 5 words, then async reset mid-cycle
    for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0);
    #2 rstn = 1'b0;
    #1;
    mq.delete(); sb.delete(); m_ovf = 0; m_udf = 0;
    check_status(0);
    chk("rdata_async_reset", rdata, 0);
    wen = 1; ren = 1; clr_err = 1; wdata = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    check_status(0);
    wen = 0; ren = 0; clr_err = 0;
    rstn = 1'b1;
    step(1, 8'h5A, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 2) == 1, DW'($urandom), ($urandom % 2) == 1, ($urandom % 8) == 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DWIDTH, default 8: data word width in bits.
REQ-002 Parameter AWIDTH, default 3: address width; depth DEPTH = 2**AWIDTH.
REQ-003 Parameter AF_LEVEL, default 6: almost_full threshold, legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty threshold, legal range 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rstn  input  1  reset; asynchronous, active-low.
REQ-007 wen  input  1  write request.
REQ-008 wdata  input  DWIDTH  write data, sampled with wen.
REQ-009 ren  input  1  read request.
REQ-010 rdata  output  DWIDTH  registered read data.
REQ-011 rvalid  output  1  rdata valid strobe, one cycle per accepted read.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_LEVEL.
REQ-015 almost_empty  output  1  count <= AE_LEVEL.
REQ-016 count  output  AWIDTH+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  sticky: write rejected since last clear.
REQ-018 underflow  output  1  sticky: read rejected since last clear.
REQ-019 clr_err  input  1  synchronous clear of overflow/underflow.

Function
REQ-020 Storage SHALL be DEPTH x DWIDTH memory, written on posedge clk only; memory contents SHALL NOT be reset.
REQ-021 Write and read pointers SHALL be AWIDTH+1 bits; low AWIDTH bits address memory, MSB is wrap bit; pointers wrap DEPTH-1 -> 0 with MSB toggle.
REQ-022 full SHALL assert when pointer MSBs differ and low bits are equal; empty SHALL assert when pointers are fully equal; both SHALL agree with count.
REQ-023 Write accepted = wen && (!full || read accepted same cycle); accepted write stores wdata at wptr and increments wptr.
REQ-024 Read accepted = ren && !empty; accepted read loads mem[rptr] into rdata at the next posedge and increments rptr; latency 1 cycle.
REQ-025 rvalid SHALL be 1 in the cycle after an accepted read, else 0; rdata SHALL hold its last value when no read is accepted.
REQ-026 Read on empty with simultaneous write: read rejected, write accepted; no fall-through.
REQ-027 count SHALL be +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-028 Rejected write (wen && not accepted) SHALL leave memory, wptr and count unchanged and set overflow next cycle.
REQ-029 Rejected read (ren && empty) SHALL leave rptr, rdata and count unchanged, keep rvalid 0, and set underflow next cycle.
REQ-030 clr_err SHALL clear both sticky flags; a same-cycle new error event SHALL win (flag set).
REQ-031 Status outputs SHALL be derived only from registered state (no combinational path from wen/ren).

Reset
REQ-032 rstn low SHALL immediately force wptr=0, rptr=0, count=0, rdata=0, rvalid=0, overflow=0, underflow=0; thus empty=1, full=0, almost_empty=1, almost_full=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued words; first read after release returns first word written after release.
REQ-034 While rstn low, wen/ren/clr_err SHALL be ignored.

Verification (DWIDTH=8, AWIDTH=3, AF_LEVEL=6, AE_LEVEL=2)
REQ-035 Write 0x11..0x88 (8 words) -> count 1..8, almost_empty drops at count 3, almost_full rises at count 6, full at 8; one more write of 0x99 -> overflow=1, count stays 8.
REQ-036 From full, read 8 words -> rdata 0x11..0x88 in order, each with rvalid one cycle after ren; empty=1 after last; ninth ren -> rvalid=0, underflow=1.
REQ-037 Wrap: write/read 20 words in a staggered stream keeping count between 1 and 5 -> data order preserved across two pointer wraps, no flags set.
REQ-038 Full plus simultaneous wen=ren with wdata 0xAA -> count stays 8, oldest word read, 0xAA stored, overflow stays 0; empty plus simultaneous wen=ren -> count 1, rvalid 0, underflow=1.
REQ-039 overflow=1, pulse clr_err -> overflow=0 next cycle; clr_err coincident with rejected write -> overflow stays 1.
REQ-040 Load 5 words, drop rstn asynchronously mid-cycle -> outputs reach reset values before next posedge; after release, write 0x5A, read -> rdata 0x5A.
